shift_sequencer: RTL



---
 rtl/shift_sequencer_pkg.sv | 24 ++
 rtl/shift_sequencer_piso_ce.sv | 41 ++++
 rtl/shift_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared states, width helper and parameter limits for shift_sequencer
package shift_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int N_MIN   = 2;
   localparam int N_MAX   = 32;
   localparam int GAP_MAX = 15;

   // Width needed to count 0..value-1; never below one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/shift_sequencer_piso_ce.sv
// rtl/shift_sequencer_piso_ce.sv - parallel-in/serial-out chain with load and clock enable
module piso_ce #(
   parameter int N         = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         LOAD,
   input  logic         CE,
   input  logic [N-1:0] D,
   output logic         Q
);

   logic [N-1:0] sr_q;
   logic [N-1:0] sr_d;

   // Zeros fill behind the data so the head reads 0 once a word is drained.
   always_comb begin
      sr_d = sr_q;
      if (LOAD) begin
         sr_d = D;
      end else if (CE) begin
         if (MSB_FIRST != 0) begin
            sr_d = {sr_q[N-2:0], 1'b0};
         end else begin
            sr_d = {1'b0, sr_q[N-1:1]};
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign Q = (MSB_FIRST != 0) ? sr_q[N-1] : sr_q[0];

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - word-to-serial controller with framing strobes and inter-word gap
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int N         = 8,
   parameter int GAP       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [N-1:0] I_DATA,
   input  logic         I_VALID,
   output logic         I_READY,
   input  logic         EN,
   output logic         O,
   output logic         O_VALID,
   output logic         O_FIRST,
   output logic         O_LAST,
   output logic         BUSY
);

   localparam int CNT_W = clog2(N);
   localparam int GAP_W = clog2(GAP_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_SHIFT = ST_SHIFT;
   localparam logic [1:0] S_GAP   = ST_GAP;
   // An out-of-range build never handshakes rather than misbehaving silently.
   localparam bit PARAMS_OK = (N >= N_MIN) && (N <= N_MAX) && (GAP >= 0) &&
                              (GAP <= GAP_MAX) && (MSB_FIRST == 0 || MSB_FIRST == 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             load;
   logic             shift_ce;

   assign I_READY = (state_q == S_IDLE) && !RESET && PARAMS_OK;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      load     = 1'b0;
      shift_ce = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (I_VALID && I_READY) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (EN) begin
               shift_ce = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  gap_d   = '0;
                  state_d = (GAP > 0) ? S_GAP : S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Strobes are registered from next-state so they line up with the head bit.
      valid_d = (state_d == S_SHIFT);
      first_d = valid_d && (cnt_d == '0);
      last_d  = valid_d && (cnt_d == CNT_LAST);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   piso_ce #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .CLK   (CLK),
      .RESET (RESET),
      .LOAD  (load),
      .CE    (shift_ce),
      .D     (I_DATA),
      .Q     (O)
   );

   assign O_VALID = valid_q;
   assign O_FIRST = first_q;
   assign O_LAST  = last_q;
   assign BUSY    = busy_q;

endmodule
